hazard_tracker: RTL and testbench

//  D-stage hazard unit of the 5-stage MIPS pipeline. Consumes per-instruction Tuse/Tnew and destination info that the D-stage decoder derives from its class flags (calc_r/calc_i/load/store/beq/bgtz/jr/jal/lui/lwie).

---
 rtl/hazard_tracker.sv | 114 +++++++++++
 tb/tb_hazard_tracker.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_tracker.sv
// D-stage hazard unit: shadow E/M/W destination pipeline, stall generation,
// and D/E operand bypass selection, including late-resolved lwie destinations.
module hazard_tracker #(
  parameter logic [4:0] DYN_ALT = 5'd31
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic [4:0] d_wr_addr,
  input  logic [1:0] d_tnew,
  input  logic       d_dyn,
  input  logic [4:0] m_dyn_addr,
  output logic       stall,
  output logic [1:0] fwd_d_rs,
  output logic [1:0] fwd_d_rt,
  output logic [1:0] fwd_e_rs,
  output logic [1:0] fwd_e_rt
);

  typedef struct packed {
    logic [4:0] addr;
    logic [1:0] tnew;
    logic       dyn;
    logic [4:0] rs;
    logic [4:0] rt;
  } e_slot_t;

  typedef struct packed {
    logic [4:0] addr;
    logic [1:0] tnew;
    logic       dyn;
  } m_slot_t;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_M    = 2'b01;
  localparam logic [1:0] FWD_W    = 2'b10;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  e_slot_t    r_e;
  m_slot_t    r_m;
  logic [4:0] r_w_addr;

  logic       w_stall_rs;
  logic       w_stall_rt;
  logic [1:0] w_m_tnew_next;

  // A dyn slot may write either its nominal destination or DYN_ALT, so a
  // source matching either one must be treated as dependent.
  function automatic logic slot_match(input logic [4:0] src,
                                      input logic [4:0] addr,
                                      input logic       dyn);
    slot_match = (src != 5'd0) && ((src == addr) || (dyn && (src == DYN_ALT)));
  endfunction

  function automatic logic op_stall(input logic [4:0] src,
                                    input logic [1:0] tuse,
                                    input e_slot_t    e,
                                    input m_slot_t    m);
    logic w_e_hit;
    logic w_m_hit;
    w_e_hit  = slot_match(src, e.addr, e.dyn) && (e.tnew > tuse);
    w_m_hit  = slot_match(src, m.addr, m.dyn) && (m.tnew > tuse);
    op_stall = (tuse != TUSE_NONE) && (w_e_hit || w_m_hit);
  endfunction

  // M wins over W; a dyn instruction's M result is never bypassed because
  // its destination is not known until it reaches W.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input m_slot_t    m,
                                         input logic [4:0] w_addr);
    if (slot_match(src, m.addr, m.dyn) && !m.dyn && (m.tnew == 2'd0))
      fwd_sel = FWD_M;
    else if ((src != 5'd0) && (src == w_addr))
      fwd_sel = FWD_W;
    else
      fwd_sel = FWD_RF;
  endfunction

  always_comb begin
    w_stall_rs = op_stall(d_rs, d_tuse_rs, r_e, r_m);
    w_stall_rt = op_stall(d_rt, d_tuse_rt, r_e, r_m);
    stall      = w_stall_rs || w_stall_rt;
  end

  always_comb begin
    fwd_d_rs = fwd_sel(d_rs,   r_m, r_w_addr);
    fwd_d_rt = fwd_sel(d_rt,   r_m, r_w_addr);
    fwd_e_rs = fwd_sel(r_e.rs, r_m, r_w_addr);
    fwd_e_rt = fwd_sel(r_e.rt, r_m, r_w_addr);
  end

  always_comb begin
    w_m_tnew_next = (r_e.tnew == 2'd0) ? 2'd0 : (r_e.tnew - 2'd1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_e      <= '0;
      r_m      <= '0;
      r_w_addr <= 5'd0;
    end else begin
      if (stall)
        r_e <= '0;
      else
        r_e <= '{addr: d_wr_addr, tnew: d_tnew, dyn: d_dyn, rs: d_rs, rt: d_rt};
      r_m      <= '{addr: r_e.addr, tnew: w_m_tnew_next, dyn: r_e.dyn};
      r_w_addr <= r_m.dyn ? m_dyn_addr : r_m.addr;
    end
  end

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed bench for hazard_tracker: instruction pairs driven into D, with
// stall and bypass selects checked against hand-derived values.
module tb_hazard_tracker;

  logic       clk;
  logic       reset;
  logic [4:0] d_rs;
  logic [4:0] d_rt;
  logic [1:0] d_tuse_rs;
  logic [1:0] d_tuse_rt;
  logic [4:0] d_wr_addr;
  logic [1:0] d_tnew;
  logic       d_dyn;
  logic [4:0] m_dyn_addr;
  logic       stall;
  logic [1:0] fwd_d_rs;
  logic [1:0] fwd_d_rt;
  logic [1:0] fwd_e_rs;
  logic [1:0] fwd_e_rt;

  int checks = 0;
  int errors = 0;

  hazard_tracker dut (
    .clk        (clk),
    .reset      (reset),
    .d_rs       (d_rs),
    .d_rt       (d_rt),
    .d_tuse_rs  (d_tuse_rs),
    .d_tuse_rt  (d_tuse_rt),
    .d_wr_addr  (d_wr_addr),
    .d_tnew     (d_tnew),
    .d_dyn      (d_dyn),
    .m_dyn_addr (m_dyn_addr),
    .stall      (stall),
    .fwd_d_rs   (fwd_d_rs),
    .fwd_d_rt   (fwd_d_rt),
    .fwd_e_rs   (fwd_e_rs),
    .fwd_e_rt   (fwd_e_rt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_d(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] tu_rs, input logic [1:0] tu_rt,
                       input logic [4:0] wr, input logic [1:0] tnew,
                       input logic dyn);
    d_rs      = rs;
    d_rt      = rt;
    d_tuse_rs = tu_rs;
    d_tuse_rt = tu_rt;
    d_wr_addr = wr;
    d_tnew    = tnew;
    d_dyn     = dyn;
  endtask

  task automatic set_nop();
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    set_nop();
    m_dyn_addr = 5'd0;
    repeat (3) tick();
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] e_stall,
                         input logic [1:0] e_drs, input logic [1:0] e_drt,
                         input logic [1:0] e_ers, input logic [1:0] e_ert);
    chk({tag, "_stall"},    {1'b0, stall}, e_stall);
    chk({tag, "_fwd_d_rs"}, fwd_d_rs, e_drs);
    chk({tag, "_fwd_d_rt"}, fwd_d_rt, e_drt);
    chk({tag, "_fwd_e_rs"}, fwd_e_rs, e_ers);
    chk({tag, "_fwd_e_rt"}, fwd_e_rt, e_ert);
  endtask

  initial begin
    reset      = 1'b1;
    m_dyn_addr = 5'd0;
    set_nop();
    #12;
    chk_all("reset", 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
    reset = 1'b0;
    tick();

    // add $1,$2,$3 ; sub $4,$1,$5
    set_d(5'd2, 5'd3, 2'd1, 2'd1, 5'd1, 2'd1, 1'b0);
    #1 chk("add_nostall", {1'b0, stall}, 2'd0);
    tick();
    set_d(5'd1, 5'd5, 2'd1, 2'd1, 5'd4, 2'd1, 1'b0);
    #1 chk("sub_nostall", {1'b0, stall}, 2'd0);
    tick();
    set_nop();
    #1 chk("sub_fwd_e_rs", fwd_e_rs, 2'b01);
    chk("sub_fwd_e_rt", fwd_e_rt, 2'b00);
    flush();

    // lw $2 ; beq $2,$0
    set_d(5'd0, 5'd2, 2'd1, 2'd3, 5'd2, 2'd2, 1'b0);
    tick();
    set_d(5'd2, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0);
    #1 chk("beq_stall1", {1'b0, stall}, 2'd1);
    chk("beq_fwd1", fwd_d_rs, 2'b00);
    tick();
    chk("beq_stall2", {1'b0, stall}, 2'd1);
    tick();
    chk("beq_stall3", {1'b0, stall}, 2'd0);
    chk("beq_fwd_d_rs", fwd_d_rs, 2'b10);
    chk("beq_fwd_d_rt", fwd_d_rt, 2'b00);
    flush();

    // lw $2 ; add $6,$2,$7
    set_d(5'd0, 5'd2, 2'd1, 2'd3, 5'd2, 2'd2, 1'b0);
    tick();
    set_d(5'd2, 5'd7, 2'd1, 2'd1, 5'd6, 2'd1, 1'b0);
    #1 chk("lwadd_stall1", {1'b0, stall}, 2'd1);
    tick();
    chk("lwadd_stall2", {1'b0, stall}, 2'd0);
    chk("lwadd_fwd_d_rs", fwd_d_rs, 2'b00);
    tick();
    set_nop();
    #1 chk("lwadd_fwd_e_rs", fwd_e_rs, 2'b10);
    chk("lwadd_fwd_e_rt", fwd_e_rt, 2'b00);
    flush();

    // lwie rt=$3 ; add $8,$31,$0 with destination resolving to $31
    set_d(5'd0, 5'd3, 2'd1, 2'd3, 5'd3, 2'd2, 1'b1);
    tick();
    set_d(5'd31, 5'd0, 2'd1, 2'd1, 5'd8, 2'd1, 1'b0);
    #1 chk("dyn31_stall1", {1'b0, stall}, 2'd1);
    tick();
    m_dyn_addr = 5'd31;
    #1 chk("dyn31_stall2", {1'b0, stall}, 2'd0);
    chk("dyn31_no_m_fwd", fwd_d_rs, 2'b00);
    tick();
    set_nop();
    m_dyn_addr = 5'd0;
    #1 chk("dyn31_fwd_e_rs", fwd_e_rs, 2'b10);
    flush();

    // lwie rt=$3 ; add $8,$31,$0 with destination resolving to $3
    set_d(5'd0, 5'd3, 2'd1, 2'd3, 5'd3, 2'd2, 1'b1);
    tick();
    set_d(5'd31, 5'd0, 2'd1, 2'd1, 5'd8, 2'd1, 1'b0);
    #1 chk("dyn3_stall1", {1'b0, stall}, 2'd1);
    tick();
    m_dyn_addr = 5'd3;
    #1 chk("dyn3_stall2", {1'b0, stall}, 2'd0);
    tick();
    set_nop();
    m_dyn_addr = 5'd0;
    #1 chk("dyn3_fwd_e_rs", fwd_e_rs, 2'b00);
    flush();

    // addi $9,$0,5 ; sw $9,0($10) ; sw $9 again while addi sits in W
    set_d(5'd0, 5'd9, 2'd1, 2'd3, 5'd9, 2'd1, 1'b0);
    tick();
    set_d(5'd10, 5'd9, 2'd1, 2'd2, 5'd0, 2'd0, 1'b0);
    #1 chk("sw_nostall", {1'b0, stall}, 2'd0);
    tick();
    set_nop();
    #1 chk("sw_fwd_e_rt", fwd_e_rt, 2'b01);
    chk("sw_fwd_e_rs", fwd_e_rs, 2'b00);
    tick();
    set_d(5'd10, 5'd9, 2'd1, 2'd2, 5'd0, 2'd0, 1'b0);
    #1 chk("sw_fwd_d_rt_w", fwd_d_rt, 2'b10);
    flush();

    // two writers of $5: the younger one in M beats the older in W
    set_d(5'd0, 5'd5, 2'd1, 2'd3, 5'd5, 2'd1, 1'b0);
    tick();
    #1 chk("prio_nostall", {1'b0, stall}, 2'd0);
    tick();
    set_nop();
    tick();
    set_d(5'd5, 5'd0, 2'd1, 2'd1, 5'd6, 2'd1, 1'b0);
    #1 chk("prio_fwd_d_rs", fwd_d_rs, 2'b01);
    chk("prio_stall", {1'b0, stall}, 2'd0);
    flush();

    // jal (tnew 0) must saturate in M, so jr $31 forwards without stalling
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 2'd0, 1'b0);
    tick();
    set_nop();
    tick();
    set_d(5'd31, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0);
    #1 chk("jal_sat_stall", {1'b0, stall}, 2'd0);
    chk("jal_fwd_d_rs", fwd_d_rs, 2'b01);
    flush();

    // lw $0 ; beq $0,$0 never interacts
    set_d(5'd0, 5'd0, 2'd1, 2'd3, 5'd0, 2'd2, 1'b0);
    tick();
    set_d(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0);
    #1 chk_all("zero_a", 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
    tick();
    chk_all("zero_b", 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
    flush();

    // asynchronous reset in the middle of a lw->beq stall
    set_d(5'd0, 5'd2, 2'd1, 2'd3, 5'd2, 2'd2, 1'b0);
    tick();
    set_d(5'd2, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0);
    #1 chk("rst_pre_stall", {1'b0, stall}, 2'd1);
    reset = 1'b1;
    #1 chk_all("rst_async", 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
    #2 reset = 1'b0;
    #1 chk("rst_post_stall", {1'b0, stall}, 2'd0);
    tick();
    chk("rst_clean_stall", {1'b0, stall}, 2'd0);
    chk("rst_clean_fwd_e_rs", fwd_e_rs, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
